// File: rtl/ex_mem_stage_if.sv
// EX -> MEM stage bus: EX-side instruction handshake and the MEM-side result handshake.
// The stage itself connects through the slave modport; the environment drives the master modport.
interface ex_mem_stage_if #(
    parameter int DATA_W  = 32,
    parameter int FUNCT_W = 6,
    parameter int REG_AW  = 5
);
    logic               ex_valid;
    logic               ex_ready;
    logic [FUNCT_W-1:0] ex_funct;
    logic [DATA_W-1:0]  ex_result_sum;
    logic               ex_overflow_sum;
    logic               ex_lt;
    logic               ex_wr_en;
    logic [REG_AW-1:0]  ex_wr_addr;
    logic [31:0]        ex_pc;

    logic               mem_valid;
    logic               mem_ready;
    logic [DATA_W-1:0]  mem_result;
    logic               mem_wr_en;
    logic [REG_AW-1:0]  mem_wr_addr;
    logic [31:0]        mem_pc;
    logic               mem_exc_ovf;

    modport master (
        output ex_valid, ex_funct, ex_result_sum, ex_overflow_sum, ex_lt,
               ex_wr_en, ex_wr_addr, ex_pc, mem_ready,
        input  ex_ready, mem_valid, mem_result, mem_wr_en, mem_wr_addr,
               mem_pc, mem_exc_ovf
    );

    modport slave (
        input  ex_valid, ex_funct, ex_result_sum, ex_overflow_sum, ex_lt,
               ex_wr_en, ex_wr_addr, ex_pc, mem_ready,
        output ex_ready, mem_valid, mem_result, mem_wr_en, mem_wr_addr,
               mem_pc, mem_exc_ovf
    );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with result select, overflow qualification and a one-entry skid buffer.
// Optional: define EX_MEM_OVF_EXC_EN to enable the ADD/SUB arithmetic-overflow exception.
module ex_mem_stage #(
    parameter int DATA_W  = 32,
    parameter int FUNCT_W = 6,
    parameter int REG_AW  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    ex_mem_stage_if.slave    bus
);

    localparam logic [FUNCT_W-1:0] FUNCT_SLT  = 6'b101010;
    localparam logic [FUNCT_W-1:0] FUNCT_SLTU = 6'b101011;
`ifdef EX_MEM_OVF_EXC_EN
    localparam logic [FUNCT_W-1:0] FUNCT_ADD  = 6'b100000;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB  = 6'b100010;
`endif

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              wr_en;
        logic [REG_AW-1:0] wr_addr;
        logic [31:0]       pc;
`ifdef EX_MEM_OVF_EXC_EN
        logic              exc;
`endif
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    function automatic logic [DATA_W-1:0] sel_result(
        input logic [FUNCT_W-1:0] funct,
        input logic [DATA_W-1:0]  sum,
        input logic               lt
    );
        logic [DATA_W-1:0] r;
        case (funct)
            FUNCT_SLT, FUNCT_SLTU: r = {{(DATA_W-1){1'b0}}, lt};
            default:               r = sum;
        endcase
        return r;
    endfunction

`ifdef EX_MEM_OVF_EXC_EN
    // Only the trapping add/sub forms raise the exception; ADDU/SUBU wrap silently.
    function automatic logic ovf_exc(
        input logic [FUNCT_W-1:0] funct,
        input logic               ovf
    );
        logic e;
        case (funct)
            FUNCT_ADD, FUNCT_SUB: e = ovf;
            default:              e = 1'b0;
        endcase
        return e;
    endfunction
`endif

    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   ex_ready_q, ex_ready_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t new_entry_s;
    logic   accept_s;
    logic   fire_s;

    // Build the entry that an accepted EX instruction would store.
    always_comb begin
        new_entry_s         = entry_t'({ENTRY_W{1'b0}});
        new_entry_s.result  = sel_result(bus.ex_funct, bus.ex_result_sum, bus.ex_lt);
        new_entry_s.wr_addr = bus.ex_wr_addr;
        new_entry_s.pc      = bus.ex_pc;
`ifdef EX_MEM_OVF_EXC_EN
        new_entry_s.exc     = ovf_exc(bus.ex_funct, bus.ex_overflow_sum);
        new_entry_s.wr_en   = bus.ex_wr_en & ~new_entry_s.exc;
`else
        new_entry_s.wr_en   = bus.ex_wr_en;
`endif
    end

    // Next-state for the main/skid pair; flush wins over accept and fire.
    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;
        accept_s     = bus.ex_valid & ex_ready_q;
        fire_s       = main_valid_q & bus.mem_ready;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            main_d.wr_en = 1'b0;
        end else if (skid_valid_q) begin
            // ex_ready was low, so nothing can be accepted while the skid is occupied.
            if (fire_s) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else begin
                main_d       = main_q;
            end
        end else if (!main_valid_q || fire_s) begin
            if (accept_s) begin
                main_d       = new_entry_s;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
                main_d.wr_en = 1'b0;
            end
        end else begin
            if (accept_s) begin
                skid_d       = new_entry_s;
                skid_valid_d = 1'b1;
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end

        ex_ready_d = ~skid_valid_d;
    end

    // State registers; async reset clears both entries and opens the input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            ex_ready_q   <= 1'b1;
            main_q       <= entry_t'({ENTRY_W{1'b0}});
            skid_q       <= entry_t'({ENTRY_W{1'b0}});
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            ex_ready_q   <= ex_ready_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

    assign bus.ex_ready    = ex_ready_q;
    assign bus.mem_valid   = main_valid_q;
    assign bus.mem_result  = main_q.result;
    assign bus.mem_wr_en   = main_q.wr_en;
    assign bus.mem_wr_addr = main_q.wr_addr;
    assign bus.mem_pc      = main_q.pc;
`ifdef EX_MEM_OVF_EXC_EN
    assign bus.mem_exc_ovf = main_q.exc;
`else
    logic unused_ovf_s;
    assign unused_ovf_s    = bus.ex_overflow_sum;
    assign bus.mem_exc_ovf = 1'b0;
`endif

endmodule
